md_sequencer: RTL and testbench

MD_SEQUENCER -- requirements
Module: md_sequencer

---
 rtl/md_sequencer.sv | 125 ++++++++++++
 tb/tb_md_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/md_sequencer.sv
// Control sequencer for an iterative multiply/divide datapath: LOAD, then N step cycles, then a one-cycle DONE pulse.
// Optional macro MD_DIV0_EARLY_EN: a divide-by-zero skips LOAD/RUN and completes in the cycle after acceptance.
module md_sequencer #(
    parameter int MULT_ITERS = 32,
    parameter int DIV_ITERS  = 32
) (
    input  logic       clk,
    input  logic       res,
    input  logic       start_mult,
    input  logic       start_div,
    input  logic       divisor_zero,
    output logic       load,
    output logic       step,
    output logic       op_div,
    output logic [4:0] iter,
    output logic       busy,
    output logic       result_rdy,
    output logic       exception
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_e;

    localparam logic [4:0] MULT_LAST = 5'(MULT_ITERS - 1);
    localparam logic [4:0] DIV_LAST  = 5'(DIV_ITERS - 1);

    state_e     state_q, state_d;
    logic [4:0] iter_q, iter_d;
    logic       op_div_q, op_div_d;
    logic       div0_q, div0_d;
    logic       load_q, load_d;
    logic       step_q, step_d;
    logic       busy_q, busy_d;
    logic       result_rdy_q, result_rdy_d;
    logic       exception_q, exception_d;
    logic [4:0] last_iter;

    assign last_iter = op_div_q ? DIV_LAST : MULT_LAST;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        iter_d   = '0;
        op_div_d = op_div_q;
        div0_d   = div0_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                // Multiply wins when both starts arrive together.
                if (start_mult) begin
                    state_d  = S_LOAD;
                    op_div_d = 1'b0;
                    div0_d   = 1'b0;
                end else if (start_div) begin
                    op_div_d = 1'b1;
                    div0_d   = divisor_zero;
`ifdef MD_DIV0_EARLY_EN
                    state_d  = divisor_zero ? S_DONE : S_LOAD;
`else
                    state_d  = S_LOAD;
`endif
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (iter_q == last_iter) begin
                    state_d = S_DONE;
                end else begin
                    iter_d = iter_q + 5'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they come straight off flops.
        load_d       = (state_d == S_LOAD);
        step_d       = (state_d == S_RUN);
        busy_d       = (state_d == S_LOAD) || (state_d == S_RUN);
        result_rdy_d = (state_d == S_DONE);
        exception_d  = (state_d == S_DONE) && div0_d;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q      <= S_IDLE;
            iter_q       <= '0;
            op_div_q     <= 1'b0;
            div0_q       <= 1'b0;
            load_q       <= 1'b0;
            step_q       <= 1'b0;
            busy_q       <= 1'b0;
            result_rdy_q <= 1'b0;
            exception_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            iter_q       <= iter_d;
            op_div_q     <= op_div_d;
            div0_q       <= div0_d;
            load_q       <= load_d;
            step_q       <= step_d;
            busy_q       <= busy_d;
            result_rdy_q <= result_rdy_d;
            exception_q  <= exception_d;
        end
    end

    assign load       = load_q;
    assign step       = step_q;
    assign op_div     = op_div_q;
    assign iter       = iter_q;
    assign busy       = busy_q;
    assign result_rdy = result_rdy_q;
    assign exception  = exception_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: a default-parameter instance plus a MULT_ITERS=1 instance sharing the same stimulus.
module tb_md_sequencer;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       start_mult = 1'b0;
    logic       start_div = 1'b0;
    logic       divisor_zero = 1'b0;

    logic       load_a, step_a, op_div_a, busy_a, rdy_a, exc_a;
    logic [4:0] iter_a;
    logic       load_b, step_b, op_div_b, busy_b, rdy_b, exc_b;
    logic [4:0] iter_b;

    int n_vec = 0;
    int n_err = 0;

    md_sequencer u_dut (
        .clk(clk), .res(res), .start_mult(start_mult), .start_div(start_div),
        .divisor_zero(divisor_zero), .load(load_a), .step(step_a), .op_div(op_div_a),
        .iter(iter_a), .busy(busy_a), .result_rdy(rdy_a), .exception(exc_a)
    );

    md_sequencer #(.MULT_ITERS(1), .DIV_ITERS(32)) u_dut_short (
        .clk(clk), .res(res), .start_mult(start_mult), .start_div(start_div),
        .divisor_zero(divisor_zero), .load(load_b), .step(step_b), .op_div(op_div_b),
        .iter(iter_b), .busy(busy_b), .result_rdy(rdy_b), .exception(exc_b)
    );

    always #5 clk = ~clk;

    // Packed as {load, step, op_div, busy, result_rdy, exception, iter[4:0]}.
    function automatic logic [10:0] dut_vec(input bit short_dut);
        if (short_dut)
            return {load_b, step_b, op_div_b, busy_b, rdy_b, exc_b, iter_b};
        return {load_a, step_a, op_div_a, busy_a, rdy_a, exc_a, iter_a};
    endfunction

    // Expected outputs k cycles after the accepting edge for an N-step operation.
    function automatic logic [10:0] exp_vec(input int k, input int n, input bit dv, input bit exc);
        logic       e_load, e_step, e_busy, e_rdy;
        logic [4:0] e_iter;
        e_load = (k == 1);
        e_step = (k >= 2) && (k <= n + 1);
        e_iter = e_step ? 5'(k - 2) : 5'd0;
        e_busy = (k <= n + 1);
        e_rdy  = (k == n + 2);
        return {e_load, e_step, dv, e_busy, e_rdy, e_rdy & exc, e_iter};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller has just driven a start at a negedge; checks cycles E0+1 onward.
    // inject_k re-pulses every start (plus divisor_zero) in that cycle; chain issues a start in the DONE cycle.
    task automatic run_op(input string tag, input bit short_dut, input bit dv, input int n,
                          input bit exc, input int inject_k, input bit chain);
        int last_k;
        last_k = chain ? n + 2 : n + 3;
        for (int k = 1; k <= last_k; k++) begin
            @(negedge clk);
            start_mult   = 1'b0;
            start_div    = 1'b0;
            divisor_zero = 1'b0;
            check($sformatf("%s k=%0d", tag, k), {21'd0, dut_vec(short_dut)},
                  {21'd0, exp_vec(k, n, dv, exc)});
            if (k == inject_k) begin
                start_mult   = 1'b1;
                start_div    = 1'b1;
                divisor_zero = 1'b1;
            end
        end
        if (chain) start_mult = 1'b1;
    endtask

    initial begin
        // Asynchronous reset before any clock edge.
        #1 res = 1'b0;
        #1;
        check("reset_async", {21'd0, dut_vec(1'b0)}, 32'd0);
        check("reset_async_short", {21'd0, dut_vec(1'b1)}, 32'd0);
        start_mult = 1'b1;
        #10;
        check("reset_held_start", {21'd0, dut_vec(1'b0)}, 32'd0);
        start_mult = 1'b0;
        @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {21'd0, dut_vec(1'b0)}, 32'd0);

        // Plain multiply; divisor_zero must be ignored.
        start_mult = 1'b1;
        divisor_zero = 1'b1;
        run_op("mult", 1'b0, 1'b0, 32, 1'b0, 0, 1'b0);

        // Plain divide; starts during LOAD are ignored.
        start_div = 1'b1;
        run_op("div", 1'b0, 1'b1, 32, 1'b0, 1, 1'b0);

        // Both starts together: multiply wins, no exception.
        start_mult = 1'b1;
        start_div = 1'b1;
        divisor_zero = 1'b1;
        run_op("both", 1'b0, 1'b0, 32, 1'b0, 0, 1'b0);

        // Divide by zero.
        start_div = 1'b1;
        divisor_zero = 1'b1;
`ifdef MD_DIV0_EARLY_EN
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start_div = 1'b0;
            divisor_zero = 1'b0;
            check($sformatf("div0_early k=%0d", k), {21'd0, dut_vec(1'b0)},
                  (k == 1) ? 32'h0000_0160 : 32'h0000_0100);
        end
`else
        run_op("div0", 1'b0, 1'b1, 32, 1'b1, 0, 1'b0);
`endif

        // Restart attempt during RUN is ignored; start in DONE is taken immediately.
        start_mult = 1'b1;
        run_op("mult_inj", 1'b0, 1'b0, 32, 1'b0, 10, 1'b1);
        run_op("mult_chain", 1'b0, 1'b0, 32, 1'b0, 0, 1'b0);

        // Mid-operation asynchronous reset aborts without a result.
        start_mult = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            start_mult = 1'b0;
        end
        @(posedge clk);
        #2 res = 1'b0;
        #1;
        check("abort_async", {21'd0, dut_vec(1'b0)}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("abort_hold k=%0d", k), {21'd0, dut_vec(1'b0)}, 32'd0);
        end
        res = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            check($sformatf("abort_quiet k=%0d", k), {21'd0, dut_vec(1'b0)}, 32'd0);
        end
        start_mult = 1'b1;
        run_op("mult_after_abort", 1'b0, 1'b0, 32, 1'b0, 0, 1'b0);

        // Single-iteration multiply on the short instance, then a full divide on it.
        start_mult = 1'b1;
        run_op("mult_n1", 1'b1, 1'b0, 1, 1'b0, 0, 1'b0);
        repeat (35) @(negedge clk);
        check("long_idle", {21'd0, dut_vec(1'b0)}, 32'd0);
        start_div = 1'b1;
        run_op("div_short", 1'b1, 1'b1, 32, 1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
